// File: rtl/axi_wr_master.sv
// axi_wr_master
//   AXI4 write master: turns one controller write request into a single AXI4
//   INCR burst (AW, then len+1 W beats, then B). One burst in flight at a time.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_start          request level, sampled only while idle
//   wr_addr, wr_len   burst start byte address / beats-1, latched one cycle
//                     after the request is accepted
//   wr_data           first-word-fall-through FIFO output, passed to WDATA
//   wr_ready          high only while idle
//   writing           W handshake this cycle; FIFO pop / address-advance strobe
//   wr_done           one-cycle pulse after the B handshake
//   wr_err            sticky, set on a non-OKAY BRESP, cleared only by reset
//   m_axi_aw*/w*/b*   AXI4 write address, data and response channels
module axi_wr_master #(
  parameter int unsigned AXI_ID_W = 4,
  parameter int unsigned AXI_ID   = 0
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                wr_start,
  input  logic [29:0]         wr_addr,
  input  logic [7:0]          wr_len,
  input  logic [63:0]         wr_data,
  output logic                wr_ready,
  output logic                writing,
  output logic                wr_done,
  output logic                wr_err,

  output logic [AXI_ID_W-1:0] m_axi_awid,
  output logic [29:0]         m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,

  output logic [63:0]         m_axi_wdata,
  output logic [7:0]          m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,

  input  logic [AXI_ID_W-1:0] m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_AW,
    ST_W,
    ST_B
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_ready_q, wr_ready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        wr_done_q, wr_done_d;
  logic        wr_err_q, wr_err_d;

  logic        beat;
  logic        last_beat;

  // BID is not checked: only one burst with a fixed ID is ever outstanding.
  logic        unused_bid;
  assign unused_bid = &{1'b0, m_axi_bid};

  assign beat      = wvalid_q & m_axi_wready;
  assign last_beat = wvalid_q & (cnt_q == len_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wr_done_d = 1'b0;
    wr_err_d  = wr_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (wr_start) begin
          state_d = ST_START;
        end
      end
      // Latching one cycle after acceptance lets the controller settle its
      // length register after its own start edge.
      ST_START: begin
        addr_d  = wr_addr;
        len_d   = wr_len;
        cnt_d   = '0;
        state_d = ST_AW;
      end
      ST_AW: begin
        if (awvalid_q & m_axi_awready) begin
          state_d = ST_W;
        end
      end
      ST_W: begin
        if (beat) begin
          cnt_d = cnt_q + 8'd1;
          if (last_beat) begin
            state_d = ST_B;
          end
        end
      end
      ST_B: begin
        if (bready_q & m_axi_bvalid) begin
          state_d   = ST_IDLE;
          wr_done_d = 1'b1;
          if (m_axi_bresp != 2'b00) begin
            wr_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs are decoded from the next state so they are registered
    // yet line up exactly with the state they belong to.
    wr_ready_d = (state_d == ST_IDLE);
    awvalid_d  = (state_d == ST_AW);
    wvalid_d   = (state_d == ST_W);
    bready_d   = (state_d == ST_B);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wr_ready_q <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      wr_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wr_ready_q <= wr_ready_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      wr_done_q  <= wr_done_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign wr_ready      = wr_ready_q;
  assign writing       = beat;
  assign wr_done       = wr_done_q;
  assign wr_err        = wr_err_q;

  assign m_axi_awid    = AXI_ID[AXI_ID_W-1:0];
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'b011;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = '0;
  assign m_axi_awqos   = '0;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = last_beat;
  assign m_axi_wvalid  = wvalid_q;

  assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_wr_master.sv
module tb_axi_wr_master;

  logic        clk;
  logic        rst_n;
  logic        wr_start;
  logic [29:0] wr_addr;
  logic [7:0]  wr_len;
  logic [63:0] wr_data;
  logic        wr_ready, writing, wr_done, wr_err;
  logic [3:0]  awid;
  logic [29:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  axi_wr_master #(.AXI_ID_W(4), .AXI_ID(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
    .wr_ready(wr_ready), .writing(writing), .wr_done(wr_done), .wr_err(wr_err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
    .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awqos(awqos),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FWFT FIFO model: head word is a function of the pop pointer.
  logic [31:0] ptr = 0;
  function automatic logic [63:0] fdata(input logic [31:0] p);
    return {p ^ 32'hA5A5_5A5A, p};
  endfunction
  assign wr_data = fdata(ptr);
  always @(posedge clk) if (writing) ptr <= ptr + 1;

  // Slave model, updated just after each rising edge.
  int          aw_delay = 1;
  int          aw_cnt = 0;
  bit          wmode = 0;
  bit          wtog = 1;
  logic [1:0]  bresp_cfg = 2'b00;
  assign bid = 4'h0;
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
  end
  always @(posedge clk or negedge rst_n) begin
    #1;
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0; aw_cnt = 0; wtog = 1;
    end else begin
      if (awvalid) aw_cnt = aw_cnt + 1; else aw_cnt = 0;
      awready = awvalid && (aw_cnt >= aw_delay);
      if (!wmode) wready = 1;
      else if (wvalid) begin wready = wtog; wtog = !wtog; end
      else begin wready = 0; wtog = 1; end
      bvalid = bready;
      bresp  = bready ? bresp_cfg : 2'b00;
    end
  end

  // Scoreboard queues.
  typedef struct { logic [29:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [63:0] data; logic last; } w_t;
  aw_t  aw_q[$];
  w_t   w_q[$];
  logic b_q[$];
  logic exp_err = 0;

  int wcnt = 0, awv_cnt = 0, busy_cnt = 0, done_cnt = 0, aw_hs = 0;

  // Monitor: compares against the queues whenever the DUT presents something.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!wr_ready) busy_cnt++;
      if (awvalid) awv_cnt++;
      if (awvalid && awready) begin
        aw_hs++;
        if (aw_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL aw_extra: got addr 0x%0h expected no AW", awaddr);
        end else begin
          aw_t e;
          e = aw_q.pop_front();
          chk("awaddr", awaddr, e.addr);
          chk("awlen", awlen, e.len);
          chk("aw_const", {awid, awsize, awburst, awlock, awcache, awprot, awqos},
              {4'h0, 3'b011, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0});
        end
      end
      if (wvalid && !wready && w_q.size() > 0) chk("wdata_stall", wdata, w_q[0].data);
      if (writing) begin
        wcnt++;
        if (w_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_extra: got data 0x%0h expected no beat", wdata);
        end else begin
          w_t e;
          e = w_q.pop_front();
          chk("wdata", wdata, e.data);
          chk("wlast", wlast, e.last);
          chk("wstrb", wstrb, 8'hFF);
        end
      end else if (wlast && !wvalid) begin
        chk("wlast_idle", wlast, 0);
      end
      if (wr_done) begin
        done_cnt++;
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_extra: got wr_done 1 expected 0");
        end else chk("wr_err", wr_err, b_q.pop_front());
      end
    end
  end

  task automatic run_burst(input logic [29:0] a, input logic [7:0] l, input bit late,
                           input logic [7:0] l_late, input logic [1:0] br, input bit poke);
    logic [7:0] el;
    int snap;
    bit ok;
    el = late ? l_late : l;
    aw_q.push_back('{a, el});
    for (int unsigned i = 0; i <= el; i++) w_q.push_back('{fdata(ptr + i), (i == el)});
    if (br != 2'b00) exp_err = 1;
    b_q.push_back(exp_err);
    bresp_cfg = br;
    snap = done_cnt;
    @(negedge clk);
    wr_addr = a; wr_len = l; wr_start = 1;
    wcnt = 0; awv_cnt = 0; busy_cnt = 0;
    @(negedge clk);
    wr_start = 0;
    if (late) wr_len = l_late;
    if (poke) begin
      ok = 0;
      for (int c = 0; c < 100 && !ok; c++) begin @(negedge clk); if (wvalid) ok = 1; end
      chk("poke_wait", ok, 1);
      wr_start = 1; @(negedge clk); @(negedge clk); wr_start = 0;
    end
    ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk); #1;
      if (done_cnt != snap) ok = 1;
    end
    chk("done_timeout", ok, 1);
    chk("wr_ready_back", wr_ready, 1);
    chk("writing_cycles", wcnt, el + 1);
    if (!wmode && aw_delay == 1) chk("occupancy", busy_cnt, el + 4);
  endtask

  initial begin
    bit ok;
    int hs0;
    rst_n = 0; wr_start = 0; wr_addr = 0; wr_len = 0;
    #3;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_valids", {awvalid, wvalid, wlast, bready, wr_done, wr_err}, 6'b0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_awlen", awlen, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("idle_wr_ready", wr_ready, 1);

    // Nominal 16-beat burst.
    run_burst(30'h100, 8'd15, 0, 0, 2'b00, 0);
    // Single beat.
    run_burst(30'h2000, 8'd0, 0, 0, 2'b00, 0);
    // Backpressure: AW held 5 cycles, W ready alternating.
    aw_delay = 5; wmode = 1;
    run_burst(30'h3F8, 8'd7, 0, 0, 2'b00, 0);
    chk("awvalid_cycles", awv_cnt, 5);
    aw_delay = 1; wmode = 0;
    // Length changes one cycle after the request.
    run_burst(30'h440, 8'd15, 1, 8'd3, 2'b00, 0);
    // Error response, with a stray request during W.
    hs0 = aw_hs;
    run_burst(30'h800, 8'd5, 0, 0, 2'b10, 1);
    chk("single_aw", aw_hs - hs0, 1);
    chk("err_sticky", wr_err, 1);
    run_burst(30'h900, 8'd2, 0, 0, 2'b00, 0);
    chk("err_still", wr_err, 1);

    // Reset mid-burst after the third beat.
    aw_q.push_back('{30'h1000, 8'd15});
    for (int unsigned i = 0; i <= 15; i++) w_q.push_back('{fdata(ptr + i), (i == 15)});
    @(negedge clk);
    wr_addr = 30'h1000; wr_len = 8'd15; wr_start = 1; wcnt = 0;
    @(negedge clk);
    wr_start = 0;
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin @(negedge clk); #1; if (wcnt == 3) ok = 1; end
    chk("beat3_wait", ok, 1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("mid_rst_valids", {awvalid, wvalid, wlast, bready, wr_ready, writing, wr_done}, 7'b0);
    chk("mid_rst_err", wr_err, 0);
    aw_q.delete(); w_q.delete(); b_q.delete(); exp_err = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", wr_ready, 1);
    run_burst(30'h1800, 8'd3, 0, 0, 2'b00, 0);

    chk("aw_q_empty", aw_q.size(), 0);
    chk("w_q_empty", w_q.size(), 0);
    chk("b_q_empty", b_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_wr_master.md
# axi_wr_master

AXI4 write master that turns the controller-side write request (start pulse level, 30-bit byte address, burst length, 64-bit data from a first-word-fall-through write FIFO) into one AXI4 INCR burst on the AW/W/B channels toward the DDR3 memory-interface slave port. It is the responder to the write controller. It reports `wr_ready` (idle, can accept a request) and `writing` (a data beat is transferred this cycle, used directly as the FIFO pop and as the controller's address-advance strobe). One burst is in flight at a time.

## Interface
- `AXI_ID_W`, 4, width of AWID/BID
- `AXI_ID`, 0, constant ID driven on AWID
- `clk`  in  1  AXI clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_start`  in  1  request level from controller; sampled only in IDLE
- `wr_addr`  in  30  burst start byte address; latched in START
- `wr_len`  in  8  AXI burst length (beats-1); latched in START
- `wr_data`  in  64  FWFT FIFO output; valid whenever `writing` can occur
- `wr_ready`  out  1  1 only in IDLE
- `writing`  out  1  `m_axi_wvalid & m_axi_wready` (combinational); FIFO rd_en
- `wr_done`  out  1  one-cycle pulse on B handshake
- `wr_err`  out  1  sticky; set on BRESP != 2'b00; cleared only by reset
- `m_axi_awid`  out  AXI_ID_W  = AXI_ID
- `m_axi_awaddr`  out  30  latched address
- `m_axi_awlen`  out  8  latched length
- `m_axi_awsize`  out  3  constant 3'b011 (8 bytes)
- `m_axi_awburst`  out  2  constant 2'b01 (INCR)
- `m_axi_awlock` / `awcache` / `awprot` / `awqos`  out  1/4/3/4  constants 0 / 4'b0011 / 0 / 0
- `m_axi_awvalid`  out  1
- `m_axi_awready`  in  1
- `m_axi_wdata`  out  64  = `wr_data` (pass-through)
- `m_axi_wstrb`  out  8  constant 8'hFF
- `m_axi_wlast`  out  1
- `m_axi_wvalid`  out  1
- `m_axi_wready`  in  1
- `m_axi_bid`  in  AXI_ID_W  ignored
- `m_axi_bresp`  in  2
- `m_axi_bvalid`  in  1
- `m_axi_bready`  out  1

## Operation
- FSM states: IDLE, START, AW, W, B. Reset state IDLE.
- IDLE: `wr_ready`=1. `wr_start`=1 -> START.
- START (1 cycle): latch `wr_addr` -> addr reg, `wr_len` -> len reg, clear beat counter -> AW. The one-cycle delay gives the controller time to update its length register after its start rising edge.
- AW: `awvalid`=1. On `awvalid & awready` -> W.
- W: `wvalid`=1. The 8-bit beat counter increments on each `writing`. `wlast` = `wvalid & (cnt == len)`. On `writing & wlast` -> B.
- B: `bready`=1. On `bvalid` -> IDLE. `wr_done` pulses, and `wr_err` is set if `bresp != 0`.
- `wr_start` outside IDLE is ignored, and no request is queued.
- AW is always completed before the first W beat (no write-before-address).
- The counter needs no wrap handling: max len 255, and the counter is reset in START.
- Wrap-around of the address range and burst truncation belong to the controller. This block sends exactly the `len+1` beats it latched.
- An `rst_n` assertion at any time (mid-AW, mid-W, mid-B) forces IDLE asynchronously and drops all valids/readies. The slave is assumed to be reset together with this block.

## Timing
- Reset values: `wr_ready`=0 while in reset, then 1 from IDLE. `awvalid`=`wvalid`=`wlast`=`bready`=`wr_done`=`wr_err`=0. `awaddr`/`awlen` registers are 0.
- `awvalid`, `wvalid`, `bready`, `wr_done` and `wr_ready` are registered, decoded from the state register. `writing` and `wlast` are combinational.
- Latency from `wr_start` high at edge k (in IDLE):
  - edge k+1: enter START, `wr_ready`=0.
  - edge k+2: enter AW, `awvalid`=1.
- With awready held high: AW handshake in cycle k+2..k+3, first W beat in cycle k+3..k+4.
- Minimum burst occupancy, with all slave readies held high: 1 (START) + 1 (AW) + (len+1) (W) + 1 (B) cycles, then IDLE. `wr_ready` returns to 1 the cycle after the B handshake.
- `wvalid` stays high continuously through W regardless of `wready`. `wdata` follows FIFO dout, which only advances on `writing`, so data is stable while stalled.
- `awaddr`/`awlen` are stable from entry to AW until the next START.

## Test plan
- Nominal: `wr_addr`=0x100, `wr_len`=15, all slave readies high. Expect 1 AW with awaddr 0x100 and awlen 15, 16 W beats with data equal to the FIFO sequence, wlast only on beat 16, `writing` high for exactly 16 cycles, `wr_done` pulse, `wr_ready` back high.
- Single beat: `wr_len`=0. Expect wlast on the first and only beat, then B, then IDLE. Counter behaviour checked.
- Backpressure: awready delayed 5 cycles; wready toggled 1-0-1-0 over `wr_len`=7. Expect `awvalid` held for 5 cycles, exactly 8 `writing` cycles, and wdata stable during each stall.
- Late length update: `wr_len` changes from 15 to 3 one cycle after `wr_start` rises. Expect awlen=3 and 4 beats.
- Error response: bresp=2'b10 on B. Expect `wr_err`=1 and still 1 after a following OKAY burst. `wr_start` asserted during W is ignored (only one AW seen).
- Reset mid-burst: `rst_n` low after beat 3 of 16. Expect all valids 0 immediately, IDLE, and a fresh burst accepted afterwards with the counter restarted.
